hand_bbox_finder: RTL and testbench
===================================

# hand_bbox_finder

Scans the binarised camera frame and produces the hand bounding box (left, right, top, bottom) consumed by the finger-tip counter downstream. It sits on the same pixel stream as the finger counter, sampling img_data at pixel_x/pixel_y. It rejects short white runs as noise. The box is latched once per frame, so the counter always sees a box from a completed frame.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_RUN, 4, consecutive white pixels on one row required to accept the run (≥1)
- MARGIN, 2, pixels added on each side of the box, clamped to the frame

Ports:
- vga_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- img_data  in  12  binarised pixel; white = 12'hfff, anything else is background
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- left  out  10  box left edge, registered
- right  out  10  box right edge, registered
- top  out  10  box top edge, registered
- bottom  out  10  box bottom edge, registered
- bbox_valid  out  1  last completed frame contained ≥1 accepted run
- frame_done  out  1  one-cycle pulse when the outputs update

## Operation
- New-pixel strobe: asserted when (pixel_x,pixel_y) differs from the previous cycle's value, and pixel_x<H_ACTIVE and pixel_y<V_ACTIVE. All processing is qualified by this strobe. Held coordinates are counted once.
- Run counter: saturates at MIN_RUN. On a strobe:
  - pixel_x==0: load 1 if white, else 0.
  - Otherwise: increment if white, clear if not.
- Acceptance: on a white strobe where the counter reaches MIN_RUN on this pixel, start = pixel_x−(MIN_RUN−1).
  - Update min_x with start, max_x with pixel_x, min_y and max_y with pixel_y. Set the hit flag.
  - Further white pixels while saturated update only max_x.
- Accumulator reset values: min_x=min_y=10'h3ff, max_x=max_y=0, hit=0.
- Frame end is a strobe at (H_ACTIVE−1, V_ACTIVE−1). On the same edge:
  - Latch the outputs from the accumulators, including this pixel's own contribution.
  - Pulse frame_done.
  - Reload the accumulators to their reset values.
- Output mapping when hit=1:
  - left = (min_x>MARGIN) ? min_x−MARGIN : 0
  - right = min(max_x+MARGIN, H_ACTIVE−1), computed in 11 bits
  - top and bottom follow the same rules against V_ACTIVE−1
  - bbox_valid=1
- Output mapping when hit=0: left=right=top=bottom=0 and bbox_valid=0. The downstream left<right check then disables the counter.
- Reset (any time, including mid-frame): all outputs 0, frame_done 0, accumulators and run counter at their reset values, previous-coordinate register 0. The first full frame after reset is processed normally. A partial frame is discarded only up to its end: the outputs still latch at the next frame end, built from the pixels seen since reset.

## Timing
- Outputs change only on the frame-end edge. They hold stable for the whole following frame.
- Latency: one vga_clk from the frame-end pixel presented to updated outputs and frame_done high. This aligns with the downstream frame counter incrementing on the same coordinate.
- frame_done is high for exactly one cycle per frame, even if the last coordinate is held for several cycles.
- Blanking coordinates (≥ active limits) produce no strobe. They do not clear the run counter; only pixel_x==0 does.

## Structure
- Shared package: H_ACTIVE, V_ACTIVE, COORD_W=10, WHITE=12'hfff. The finger counter is migrated to these constants too.
- One sub-module, run_filter: strobe and white in, accept/extend pulses plus run start x out. Parent holds the accumulators, clamp logic and output registers.

## Test plan
- Reset → left=right=top=bottom=0, bbox_valid=0, frame_done=0. A held reset ignores all pixels.
- White rectangle x100–199, y50–149, MIN_RUN=4, MARGIN=2 → after frame end: left=98, right=201, top=48, bottom=151, bbox_valid=1, one frame_done pulse.
- Frame containing only 3-pixel white runs plus isolated dots → outputs all 0, bbox_valid=0. Previous frame's box is replaced at frame end.
- Full-white frame → left=0, right=639, top=0, bottom=479 (clamping at every edge).
- Same rectangle with every coordinate held 2 cycles → identical box, exactly one frame_done pulse.
- rst_n pulsed low at row 300 of a frame containing the rectangle → outputs 0 immediately. The next complete frame yields 98/201/48/151.

Source files
------------

// File: rtl/hand_bbox_finder_pkg.sv
// Shared video constants and box helpers for the hand bounding-box finder
// and the finger-tip counter that consumes its box.
package hand_bbox_finder_pkg;

   localparam int COORD_W  = 10;
   localparam int PIX_W    = 12;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam logic [PIX_W-1:0] WHITE = 12'hfff;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t min_x;
      coord_t max_x;
      coord_t min_y;
      coord_t max_y;
      logic   hit;
   } acc_t;

   localparam acc_t ACC_RST = '{min_x: 10'h3ff, max_x: 10'h000,
                                min_y: 10'h3ff, max_y: 10'h000, hit: 1'b0};

   function automatic coord_t clamp_lo(input coord_t v, input int margin);
      coord_t m;
      m = coord_t'(margin);
      return (v > m) ? v - m : '0;
   endfunction

   // Sum is kept one bit wider so max+margin cannot wrap before the clamp.
   function automatic coord_t clamp_hi(input coord_t v, input int margin, input int lim);
      logic [COORD_W:0] s;
      logic [COORD_W:0] l;
      s = {1'b0, v} + (COORD_W+1)'(margin);
      l = (COORD_W+1)'(lim);
      return (s > l) ? l[COORD_W-1:0] : s[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/hand_bbox_finder_run_filter.sv
// Counts consecutive white pixels on a row and flags when a run becomes
// long enough to count as hand, or keeps growing once it already has.
module hand_bbox_finder_run_filter
   import hand_bbox_finder_pkg::*;
#(
   parameter int MIN_RUN = 4
) (
   input  logic   vga_clk,
   input  logic   rst_n,
   input  logic   strobe_i,
   input  logic   white_i,
   input  coord_t pixel_x_i,
   output logic   accept_o,
   output logic   extend_o,
   output coord_t start_x_o
);

   localparam int CNT_W = $clog2(MIN_RUN + 1);
   localparam logic [CNT_W-1:0] SAT = CNT_W'(MIN_RUN);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             row_start;

   assign row_start = (pixel_x_i == '0);

   always_comb begin
      cnt_d    = cnt_q;
      accept_o = 1'b0;
      extend_o = 1'b0;
      if (strobe_i) begin
         if (row_start)
            cnt_d = white_i ? CNT_W'(1) : '0;
         else if (!white_i)
            cnt_d = '0;
         else if (cnt_q != SAT)
            cnt_d = cnt_q + CNT_W'(1);
         // A reload at column 0 can reach saturation only when MIN_RUN is 1.
         accept_o = white_i && (cnt_d == SAT) && (row_start || (cnt_q != SAT));
         extend_o = white_i && !row_start && (cnt_q == SAT);
      end
   end

   assign start_x_o = pixel_x_i - coord_t'(MIN_RUN - 1);

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hand_bbox_finder.sv
// Accumulates the extent of accepted white runs over a frame and latches a
// margin-padded, frame-clamped bounding box at every frame end.
module hand_bbox_finder
   import hand_bbox_finder_pkg::*;
#(
   parameter int H_ACTIVE = hand_bbox_finder_pkg::H_ACTIVE,
   parameter int V_ACTIVE = hand_bbox_finder_pkg::V_ACTIVE,
   parameter int MIN_RUN  = 4,
   parameter int MARGIN   = 2
) (
   input  logic                   vga_clk,
   input  logic                   rst_n,
   input  logic [PIX_W-1:0]       img_data,
   input  logic [COORD_W-1:0]     pixel_x,
   input  logic [COORD_W-1:0]     pixel_y,
   output logic [COORD_W-1:0]     left,
   output logic [COORD_W-1:0]     right,
   output logic [COORD_W-1:0]     top,
   output logic [COORD_W-1:0]     bottom,
   output logic                   bbox_valid,
   output logic                   frame_done
);

   coord_t px_prev_q, py_prev_q;
   logic   strobe, white, frame_end, accept, extend, in_active;
   coord_t start_x;
   acc_t   acc_q, acc_d, acc_upd;
   coord_t left_q, right_q, top_q, bottom_q;
   coord_t left_d, right_d, top_d, bottom_d;
   logic   valid_q, valid_d, done_q;

   assign in_active = ({1'b0, pixel_x} < (COORD_W+1)'(H_ACTIVE)) &&
                      ({1'b0, pixel_y} < (COORD_W+1)'(V_ACTIVE));
   // Held coordinates produce a single strobe, so a stalled stream is counted once.
   assign strobe    = ((pixel_x != px_prev_q) || (pixel_y != py_prev_q)) && in_active;
   assign white     = (img_data == WHITE);
   assign frame_end = strobe && (pixel_x == coord_t'(H_ACTIVE - 1)) &&
                      (pixel_y == coord_t'(V_ACTIVE - 1));

   hand_bbox_finder_run_filter #(.MIN_RUN(MIN_RUN)) u_run_filter (
      .vga_clk   (vga_clk),
      .rst_n     (rst_n),
      .strobe_i  (strobe),
      .white_i   (white),
      .pixel_x_i (pixel_x),
      .accept_o  (accept),
      .extend_o  (extend),
      .start_x_o (start_x)
   );

   always_comb begin
      acc_upd = acc_q;
      if (accept) begin
         if (start_x < acc_q.min_x) acc_upd.min_x = start_x;
         if (pixel_x > acc_q.max_x) acc_upd.max_x = pixel_x;
         if (pixel_y < acc_q.min_y) acc_upd.min_y = pixel_y;
         if (pixel_y > acc_q.max_y) acc_upd.max_y = pixel_y;
         acc_upd.hit = 1'b1;
      end else if (extend && (pixel_x > acc_q.max_x)) begin
         acc_upd.max_x = pixel_x;
      end
      acc_d = frame_end ? ACC_RST : acc_upd;
   end

   // Built from acc_upd so the frame-end pixel's own run is part of the box.
   always_comb begin
      left_d   = '0;
      right_d  = '0;
      top_d    = '0;
      bottom_d = '0;
      valid_d  = acc_upd.hit;
      if (acc_upd.hit) begin
         left_d   = clamp_lo(acc_upd.min_x, MARGIN);
         right_d  = clamp_hi(acc_upd.max_x, MARGIN, H_ACTIVE - 1);
         top_d    = clamp_lo(acc_upd.min_y, MARGIN);
         bottom_d = clamp_hi(acc_upd.max_y, MARGIN, V_ACTIVE - 1);
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         px_prev_q <= '0;
         py_prev_q <= '0;
         acc_q     <= ACC_RST;
         left_q    <= '0;
         right_q   <= '0;
         top_q     <= '0;
         bottom_q  <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         px_prev_q <= pixel_x;
         py_prev_q <= pixel_y;
         acc_q     <= acc_d;
         done_q    <= frame_end;
         if (frame_end) begin
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            valid_q  <= valid_d;
         end
      end
   end

   assign left       = left_q;
   assign right      = right_q;
   assign top        = top_q;
   assign bottom     = bottom_q;
   assign bbox_valid = valid_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_hand_bbox_finder.sv
// Frame-level bench for hand_bbox_finder: sparse pixel streams per frame,
// expected boxes queued at the frame-end pixel and checked on frame_done.
`timescale 1ns/1ps
module tb_hand_bbox_finder;

   localparam int H = 640;
   localparam int V = 480;
   localparam int K_RECT  = 0;
   localparam int K_NOISE = 1;
   localparam int K_FULL  = 2;
   localparam int K_BR    = 3;

   typedef struct {
      int          kind;
      int          hold;
      int          rst_row;
      logic [40:0] exp;
   } vec_t;

   logic        vga_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [11:0] img_data;
   logic [9:0]  pixel_x, pixel_y;
   logic [9:0]  left, right, top, bottom;
   logic        bbox_valid, frame_done;
   logic [40:0] act_box;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [40:0] exp_q[$];
   logic [40:0] last_box = '0;
   logic [40:0] cur_exp  = '0;
   vec_t        vecs[7];

   always #5 vga_clk = ~vga_clk;

   hand_bbox_finder #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_RUN(4), .MARGIN(2)) dut (
      .vga_clk    (vga_clk),
      .rst_n      (rst_n),
      .img_data   (img_data),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .left       (left),
      .right      (right),
      .top        (top),
      .bottom     (bottom),
      .bbox_valid (bbox_valid),
      .frame_done (frame_done)
   );

   assign act_box = {left, right, top, bottom, bbox_valid};

   function automatic logic [40:0] mk(input int l, input int r, input int t, input int b,
                                      input logic v);
      return {10'(l), 10'(r), 10'(t), 10'(b), v};
   endfunction

   task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got l=%0d r=%0d t=%0d b=%0d v=%0b, required l=%0d r=%0d t=%0d b=%0d v=%0b",
                  name, act[40:31], act[30:21], act[20:11], act[10:1], act[0],
                  exp[40:31], exp[30:21], exp[20:11], exp[10:1], exp[0]);
      end
   endtask

   // Scoreboard: pop on every frame_done, otherwise outputs must hold.
   initial begin
      logic [40:0] e;
      forever begin
         @(posedge vga_clk);
         #1;
         if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_frame_done: got frame_done=1, required 0 at t=%0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("frame_box", act_box, e);
               last_box = e;
            end
         end else begin
            chk("hold_box", act_box, last_box);
         end
      end
   end

   task automatic put_pix(input int x, input int y, input logic w, input int hold);
      for (int h = 0; h < hold; h++) begin
         @(negedge vga_clk);
         pixel_x  = 10'(x);
         pixel_y  = 10'(y);
         img_data = w ? 12'hfff : 12'($urandom_range(0, 12'hffe));
         if (h == 0 && x == H-1 && y == V-1) exp_q.push_back(cur_exp);
      end
   endtask

   task automatic pulse_reset();
      @(negedge vga_clk);
      last_box = '0;
      rst_n    = 1'b0;
      #1;
      chk("reset_immediate", act_box, '0);
      chk("reset_immediate_done", {40'b0, frame_done}, '0);
      @(negedge vga_clk);
      rst_n = 1'b1;
   endtask

   task automatic scan_frame(input int kind, input int hold, input int rst_row);
      for (int y = 0; y < V; y++) begin
         if (y == rst_row) pulse_reset();
         put_pix(0, y, (kind == K_FULL) || (kind == K_NOISE && y == 201), hold);
         case (kind)
            K_RECT: if (y >= 50 && y <= 149)
               for (int x = 99; x <= 200; x++) put_pix(x, y, x >= 100 && x <= 199, hold);
            K_NOISE: begin
               if (y >= 10 && y <= 12) begin
                  for (int x = 20; x <= 27; x++) put_pix(x, y, x != 23 && x != 27, hold);
                  put_pix(40, y, 1'b1, hold);
                  put_pix(41, y, 1'b0, hold);
               end
               if (y == 200)
                  for (int x = 637; x <= 639; x++) put_pix(x, y, 1'b1, hold);
               if (y == 201) put_pix(1, y, 1'b0, hold);
               if (y == V-1) begin
                  put_pix(637, y, 1'b1, hold);
                  put_pix(638, y, 1'b1, hold);
               end
            end
            K_FULL: begin
               for (int x = 1; x <= 3; x++) put_pix(x, y, 1'b1, hold);
               for (int x = 636; x <= 639; x++) put_pix(x, y, 1'b1, hold);
            end
            K_BR: if (y == V-1)
               for (int x = 636; x <= 639; x++) put_pix(x, y, 1'b1, hold);
            default: ;
         endcase
         if (y == V-1 && kind != K_FULL && kind != K_BR) put_pix(H-1, y, 1'b0, hold);
      end
   endtask

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{K_RECT,  1, -1,  mk(98, 201, 48, 151, 1'b1)};
      vecs[1] = '{K_NOISE, 1, -1,  mk(0, 0, 0, 0, 1'b0)};
      vecs[2] = '{K_FULL,  1, -1,  mk(0, 639, 0, 479, 1'b1)};
      vecs[3] = '{K_BR,    1, -1,  mk(634, 639, 477, 479, 1'b1)};
      vecs[4] = '{K_RECT,  2, -1,  mk(98, 201, 48, 151, 1'b1)};
      vecs[5] = '{K_RECT,  1, 300, mk(0, 0, 0, 0, 1'b0)};
      vecs[6] = '{K_RECT,  1, -1,  mk(98, 201, 48, 151, 1'b1)};

      pixel_x  = '0;
      pixel_y  = '0;
      img_data = '0;
      // Held reset: white pixels including the frame-end coordinate must be ignored.
      for (int i = 0; i < 20; i++) begin
         @(negedge vga_clk);
         pixel_x  = (i % 2 == 0) ? 10'(H-1) : 10'($urandom_range(0, H-1));
         pixel_y  = (i % 2 == 0) ? 10'(V-1) : 10'($urandom_range(0, V-1));
         img_data = 12'hfff;
      end
      @(posedge vga_clk);
      #1;
      chk("reset_box", act_box, '0);
      chk("reset_frame_done", {40'b0, frame_done}, '0);
      @(negedge vga_clk);
      pixel_x  = '0;
      pixel_y  = '0;
      img_data = '0;
      rst_n    = 1'b1;

      for (int v = 0; v < 7; v++) begin
         cur_exp = vecs[v].exp;
         scan_frame(vecs[v].kind, vecs[v].hold, vecs[v].rst_row);
         repeat (3) @(negedge vga_clk);
         n_chk++;
         if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_frame_done: vector %0d got %0d pending boxes, required 0",
                     v, exp_q.size());
            exp_q.delete();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
